// File: rtl/mem_bus_arbiter_if.sv
// Shared-memory bus bundle: two requester ports, the memory-side bus and a debug owner code.
// The arbiter takes the slave view; the requesters and memory model take the master view.
interface mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  m0_req;
    logic                  m0_we;
    logic                  m0_byt;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [15:0]           m0_wdata;
    logic                  m0_gnt;
    logic                  m0_rvalid;
    logic [15:0]           m0_rdata;

    logic                  m1_req;
    logic                  m1_we;
    logic                  m1_byt;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [15:0]           m1_wdata;
    logic                  m1_gnt;
    logic                  m1_rvalid;
    logic [15:0]           m1_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  wr_mem;
    logic                  byt;
    logic [15:0]           wr_data;
    logic [15:0]           rd_data;
    logic [1:0]            owner;

    modport slave (
        input  m0_req, m0_we, m0_byt, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_byt, m1_addr, m1_wdata,
        input  rd_data,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_addr, wr_mem, byt, wr_data, owner
    );

    modport master (
        output m0_req, m0_we, m0_byt, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_byt, m1_addr, m1_wdata,
        output rd_data,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_addr, wr_mem, byt, wr_data, owner
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master shared memory bus arbiter with burst-limited grant hold and tagged 1-cycle read return.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate the winner of simultaneous requests from IDLE.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_BURST  = 8
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [7:0]            r_burst_cnt;
    logic [7:0]            w_burst_cnt_next;
    logic                  r_pend_v;
    logic                  r_pend_tag;

    logic [1:0]            w_req;
    logic [1:0]            w_we;
    logic [1:0]            w_byt;
    logic [ADDR_WIDTH-1:0] w_addr [2];
    logic [15:0]           w_wdata [2];
    logic [1:0]            w_gnt;
    logic [1:0]            w_rvalid;

    logic                  w_owned;
    logic                  w_own_idx;
    logic                  w_xfer;
    logic                  w_last;
    logic                  w_pick1;

    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic                  w_wr_mem;
    logic                  w_byt_out;
    logic [15:0]           w_wr_data;

    assign w_req      = {bus.m1_req, bus.m0_req};
    assign w_we       = {bus.m1_we,  bus.m0_we};
    assign w_byt      = {bus.m1_byt, bus.m0_byt};
    assign w_addr[0]  = bus.m0_addr;
    assign w_addr[1]  = bus.m1_addr;
    assign w_wdata[0] = bus.m0_wdata;
    assign w_wdata[1] = bus.m1_wdata;

    assign w_owned   = (r_state != IDLE);
    assign w_own_idx = (r_state == OWN1);
    assign w_xfer    = w_owned & w_req[w_own_idx];
    assign w_last    = (r_burst_cnt == BURST_LAST);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1 = M1 was the most recent owner; both masters requesting from IDLE goes to the other one.
    logic r_last_owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_owner <= 1'b1;
        end else if ((w_state_next != r_state) && (w_state_next != IDLE)) begin
            r_last_owner <= (w_state_next == OWN1);
        end
    end

    assign w_pick1 = w_req[1] & (~w_req[0] | ~r_last_owner);
`else
    assign w_pick1 = w_req[1] & ~w_req[0];
`endif

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_pick1)       w_state_next = OWN1;
                else if (w_req[0]) w_state_next = OWN0;
            end
            OWN0: begin
                if (!w_req[0])                w_state_next = w_req[1] ? OWN1 : IDLE;
                else if (w_last && w_req[1])  w_state_next = OWN1;
            end
            OWN1: begin
                if (!w_req[1])                w_state_next = w_req[0] ? OWN0 : IDLE;
                else if (w_last && w_req[0])  w_state_next = OWN0;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Saturating at the last count keeps an uncontended owner on the bus indefinitely.
    always_comb begin
        w_burst_cnt_next = r_burst_cnt;
        if (w_state_next != r_state) begin
            w_burst_cnt_next = '0;
        end else if (w_xfer && !w_last) begin
            w_burst_cnt_next = r_burst_cnt + 8'd1;
        end
    end

    always_comb begin
        w_mem_addr = '0;
        w_wr_mem   = 1'b0;
        w_byt_out  = 1'b0;
        w_wr_data  = '0;
        if (w_owned) begin
            w_mem_addr = w_addr[w_own_idx];
            w_wr_mem   = w_req[w_own_idx] & w_we[w_own_idx];
            w_byt_out  = w_byt[w_own_idx];
            w_wr_data  = w_wdata[w_own_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_burst_cnt <= '0;
            r_pend_v    <= 1'b0;
            r_pend_tag  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_burst_cnt <= w_burst_cnt_next;
            r_pend_v    <= w_xfer & ~w_we[w_own_idx];
            r_pend_tag  <= w_own_idx;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign w_gnt[gi]    = (r_state == state_t'(2'(gi + 1)));
            assign w_rvalid[gi] = r_pend_v & (r_pend_tag == 1'(gi));
        end
    endgenerate

    assign bus.m0_gnt    = w_gnt[0];
    assign bus.m1_gnt    = w_gnt[1];
    assign bus.m0_rvalid = w_rvalid[0];
    assign bus.m1_rvalid = w_rvalid[1];
    assign bus.m0_rdata  = bus.rd_data;
    assign bus.m1_rdata  = bus.rd_data;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.wr_mem    = w_wr_mem;
    assign bus.byt       = w_byt_out;
    assign bus.wr_data   = w_wr_data;
    assign bus.owner     = r_state;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: table rows plus hand-built bursts, with a read-return scoreboard queue.
module tb_mem_bus_arbiter;
    localparam int AW        = 16;
    localparam int MAX_BURST = 8;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam logic [1:0] SECOND_WIN = 2'b10;
`else
    localparam logic [1:0] SECOND_WIN = 2'b01;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    mem_bus_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(MAX_BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory macro: registered read, data valid the cycle after the address.
    logic [15:0] mem    [512];
    logic [15:0] shadow [512];
    always @(posedge clk) begin
        if (bus.wr_mem) mem[bus.mem_addr[9:1]] <= bus.wr_data;
        bus.rd_data <= mem[bus.mem_addr[9:1]];
    end

    typedef struct {
        logic        rst;
        logic        r0, w0, b0;
        logic [15:0] a0, d0;
        logic        r1, w1, b1;
        logic [15:0] a1, d1;
        logic [1:0]  own;
    } vec_t;

    typedef struct {
        logic        tag;
        logic [15:0] data;
        int          cyc;
    } rd_t;

    rd_t sb[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;

    function automatic vec_t mk(input logic rs,
                                input logic r0, input logic w0, input logic b0,
                                input logic [15:0] a0, input logic [15:0] d0,
                                input logic r1, input logic w1, input logic b1,
                                input logic [15:0] a1, input logic [15:0] d1,
                                input logic [1:0] own);
        vec_t v;
        v.rst = rs;
        v.r0 = r0; v.w0 = w0; v.b0 = b0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.b1 = b1; v.a1 = a1; v.d1 = d1;
        v.own = own;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
        end
    endtask

    task automatic step(input vec_t v);
        logic [15:0] ea, ed, xa, xd;
        logic        ew, eb, er0, er1, xt, xr, xw;
        rd_t         e;
        rst = v.rst;
        bus.m0_req = v.r0; bus.m0_we = v.w0; bus.m0_byt = v.b0;
        bus.m0_addr = v.a0; bus.m0_wdata = v.d0;
        bus.m1_req = v.r1; bus.m1_we = v.w1; bus.m1_byt = v.b1;
        bus.m1_addr = v.a1; bus.m1_wdata = v.d1;
        @(negedge clk);
        ea = '0; ed = '0; ew = 1'b0; eb = 1'b0;
        if (v.own == 2'b01) begin
            ea = v.a0; ed = v.d0; eb = v.b0; ew = v.r0 & v.w0;
        end else if (v.own == 2'b10) begin
            ea = v.a1; ed = v.d1; eb = v.b1; ew = v.r1 & v.w1;
        end
        chk("owner",    32'(bus.owner), 32'(v.own));
        chk("gnt",      32'({bus.m1_gnt, bus.m0_gnt}), 32'(v.own));
        chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
        chk("wr_mem",   32'(bus.wr_mem), 32'(ew));
        chk("byt",      32'(bus.byt), 32'(eb));
        chk("wr_data",  32'(bus.wr_data), 32'(ed));
        er0 = 1'b0; er1 = 1'b0;
        if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
            e = sb.pop_front();
            if (e.tag) er1 = 1'b1; else er0 = 1'b1;
            chk("rdata", 32'(e.tag ? bus.m1_rdata : bus.m0_rdata), 32'(e.data));
            $display("cyc=%0d M%0d read return data=%h", cyc, e.tag, e.data);
        end
        chk("rvalid", 32'({bus.m1_rvalid, bus.m0_rvalid}), 32'({er1, er0}));
        if (v.own != 2'b00) begin
            xt = (v.own == 2'b10);
            xr = xt ? v.r1 : v.r0;
            xw = xt ? v.w1 : v.w0;
            xa = xt ? v.a1 : v.a0;
            xd = xt ? v.d1 : v.d0;
            if (xr && xw) begin
                shadow[xa[9:1]] = xd;
                $display("cyc=%0d M%0d write addr=%h data=%h", cyc, xt, xa, xd);
            end else if (xr) begin
                if (!v.rst) begin
                    e.tag = xt; e.data = shadow[xa[9:1]]; e.cyc = cyc;
                    sb.push_back(e);
                end
                $display("cyc=%0d M%0d read addr=%h%s", cyc, xt, xa, v.rst ? " (reset)" : "");
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        vec_t tbl [12];
        vec_t z;
        logic [1:0]  own;
        logic [15:0] a0, a1;
        int          n0, n1;

        for (int i = 0; i < 512; i++) begin
            mem[i]    = 16'h5A00 ^ 16'(i * 37);
            shadow[i] = 16'h5A00 ^ 16'(i * 37);
        end
        rst = 1'b1;
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_byt = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_byt = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
        repeat (3) @(posedge clk);
        #1;

        z = mk(0, 0,0,0,16'h0,16'h0, 0,0,0,16'h0,16'h0, 2'b00);
        // Single M1 read, then simultaneous requests from IDLE twice.
        tbl[0]  = z;
        tbl[1]  = mk(0, 0,0,0,16'h0,16'h0,       1,0,0,16'h0300,16'h0, 2'b00);
        tbl[2]  = mk(0, 0,0,0,16'h0,16'h0,       1,0,0,16'h0300,16'h0, 2'b10);
        tbl[3]  = mk(0, 0,0,0,16'h0,16'h0,       0,0,0,16'h0,16'h0,    2'b10);
        tbl[4]  = z;
        tbl[5]  = mk(0, 1,1,0,16'h0310,16'h1111, 1,0,0,16'h0320,16'h0, 2'b00);
        tbl[6]  = mk(0, 1,1,0,16'h0310,16'h1111, 1,0,0,16'h0320,16'h0, 2'b01);
        tbl[7]  = mk(0, 0,0,0,16'h0,16'h0,       0,0,0,16'h0,16'h0,    2'b01);
        tbl[8]  = mk(0, 1,0,0,16'h0310,16'h0,    1,0,1,16'h0320,16'h0, 2'b00);
        tbl[9]  = mk(0, 1,0,0,16'h0310,16'h0,    1,0,1,16'h0320,16'h0, SECOND_WIN);
        tbl[10] = mk(0, 0,0,0,16'h0,16'h0,       0,0,0,16'h0,16'h0,    SECOND_WIN);
        tbl[11] = z;
        for (int i = 0; i < 12; i++) step(tbl[i]);

        // Both masters continuous: alternate every MAX_BURST transfers, no idle gap.
        n0 = 0; n1 = 0;
        step(mk(0, 1,1,0,16'h0100,16'hC000, 1,0,0,16'h0200,16'h0, 2'b00));
        for (int i = 0; i < 3 * MAX_BURST; i++) begin
            own = ((i / MAX_BURST) % 2 == 0) ? 2'b01 : 2'b10;
            a0  = 16'h0100 + 16'(2 * n0);
            a1  = 16'h0200 + 16'(2 * n1);
            step(mk(0, 1,1,0,a0,16'hC000 + 16'(n0), 1,0,0,a1,16'h0, own));
            if (own == 2'b01) n0++; else n1++;
        end
        step(mk(0, 0,0,0,16'h0,16'h0, 0,0,0,16'h0,16'h0, 2'b10));
        step(z);

        // Uncontended M0 burst beyond MAX_BURST, then M1 arrives at the saturated count.
        step(mk(0, 1,1,0,16'h0300,16'hB000, 0,0,0,16'h0,16'h0, 2'b00));
        for (int k = 0; k < 16; k++) begin
            if (k < 12)
                step(mk(0, 1,1,1'(k % 3 == 0),16'h0300 + 16'(2 * k),16'hB000 + 16'(k),
                        0,0,0,16'h0,16'h0, 2'b01));
            else
                step(mk(0, 1,0,0,16'h0300 + 16'(2 * (k - 12)),16'h0,
                        0,0,0,16'h0,16'h0, 2'b01));
        end
        step(mk(0, 1,1,0,16'h0330,16'hB0FF, 1,0,0,16'h0302,16'h0, 2'b01));
        step(mk(0, 0,0,0,16'h0,16'h0,       1,0,0,16'h0302,16'h0, 2'b10));
        step(mk(0, 0,0,0,16'h0,16'h0,       0,0,0,16'h0,16'h0,    2'b10));
        step(z);

        // Reset sampled on an M0 read transfer discards it.
        step(mk(0, 1,0,0,16'h0302,16'h0, 0,0,0,16'h0,16'h0, 2'b00));
        step(mk(1, 1,0,0,16'h0302,16'h0, 0,0,0,16'h0,16'h0, 2'b01));
        step(z);
        // Reset while read data is already returning.
        step(mk(0, 1,0,0,16'h0304,16'h0, 0,0,0,16'h0,16'h0, 2'b00));
        step(mk(0, 1,0,0,16'h0304,16'h0, 0,0,0,16'h0,16'h0, 2'b01));
        step(mk(1, 0,0,0,16'h0,16'h0,    0,0,0,16'h0,16'h0, 2'b01));
        step(z);
        step(z);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Arbitrates the single shared memory bus (address, write strobe, byte select, write data, read data) between two requesters.
- M0 is the loader/DMA port (UART program load, peripheral block moves); M1 is the CPU port.
- Grant is held for bursts of up to MAX_BURST transfers. Read data returns with fixed 1-cycle latency and is tagged back to the master that issued the read.
- Sits between the requesters and the memory macro, in place of the static recv_compl-style mux.

Parameters:
- ADDR_WIDTH, 16, width of memory address.
- MAX_BURST, 8, maximum consecutive transfers a master keeps the grant while the other master is requesting (legal range 1..255).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- m0_req  input  1  M0 transfer request; held with fields stable until accepted.
- m0_we  input  1  M0 write (1) / read (0).
- m0_byt  input  1  M0 byte access.
- m0_addr  input  ADDR_WIDTH  M0 address.
- m0_wdata  input  16  M0 write data.
- m0_gnt  output  1  M0 owns the bus this cycle.
- m0_rvalid  output  1  M0 read data valid.
- m0_rdata  output  16  M0 read data.
- m1_req, m1_we, m1_byt, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as M0, for the CPU port.
- mem_addr  output  ADDR_WIDTH  memory address.
- wr_mem  output  1  memory write strobe.
- byt  output  1  memory byte access.
- wr_data  output  16  memory write data.
- rd_data  input  16  memory read data, valid the cycle after the address is presented.
- owner  output  2  debug: 00 idle, 01 M0, 10 M1.

Behaviour:
- State machine: IDLE, OWN0, OWN1.
  - mX_gnt = (state == OWNX), decoded combinationally from the state register.
  - owner reflects the state.
- Transfer: occurs in any cycle with mX_req & mX_gnt. Exactly one transfer per cycle maximum.
- Bus mux (combinational):
  - In OWNX: mem_addr, byt and wr_data come from master X, and wr_mem = mX_req & mX_we.
  - In IDLE: mem_addr = 0, byt = 0, wr_data = 0, wr_mem = 0.
- IDLE transitions:
  - m0_req → OWN0, else m1_req → OWN1, else stay in IDLE.
  - A grant is visible one cycle after the request: minimum latency from idle is 1 cycle.
- OWNX transitions, evaluated at each edge (Y is the other master):
  - mX_req = 0 and mY_req = 1 → OWNY.
  - mX_req = 0 and mY_req = 0 → IDLE.
  - mX_req = 1 and a transfer happens this cycle with burst_cnt == MAX_BURST-1 and mY_req = 1 → OWNY (forced hand-off).
  - Otherwise stay in OWNX.
- burst_cnt (8 bit):
  - Clears on every state change.
  - Increments on each transfer in the current state.
  - Saturates at MAX_BURST-1 while the other master is not requesting, so the owner keeps the bus indefinitely when uncontended.
- Direct OWN0↔OWN1 hand-off has no idle cycle.
- Read return:
  - On a read transfer by X, register pend_v = 1 and pend_tag = X.
  - Next cycle: mX_rvalid = pend_v & (pend_tag == X); m0_rdata = m1_rdata = rd_data.
  - Back-to-back reads produce back-to-back rvalid pulses.
  - A read issued in the last cycle before a hand-off still returns to its issuer while the new owner transfers.
- Write transfers produce no rvalid.
- Reset (synchronous): state = IDLE, burst_cnt = 0, pend_v = 0.
  - All gnt and rvalid outputs are 0 and bus outputs are 0 in the cycle following the rst edge.
  - A read pending when reset is sampled is discarded.
- MAX_BURST = 1: strict alternation whenever both masters request continuously.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- When defined: a last_owner register (reset to M1) is updated on each entry to OWN0/OWN1. From IDLE with both requests high, grant goes to the master that is not last_owner.
- When undefined: fixed priority from IDLE, M0 wins. Forced hand-off via MAX_BURST is unchanged in both builds.

Test Plan:
1. Reset, then m1_req read addr 0x0300 → m1_gnt at cycle 1, mem_addr = 0x0300, m1_rvalid at cycle 2 with m1_rdata = model data; m0 signals stay 0.
2. Both requesters continuous, MAX_BURST = 8 → ownership alternates with exactly 8 transfers per grant, no idle cycle between owners.
3. M0 write burst 0x0300/0x0302/… while M1 idle → M0 keeps the grant beyond 8 transfers; wr_mem high each cycle with wr_data = M0 data.
4. M1 read at the last cycle before a forced hand-off to M0 → m1_rvalid the next cycle while m0_gnt = 1, m0_rvalid = 0.
5. Both requesting simultaneously from IDLE, twice: M0 wins both times without MEM_ARB_ROUND_ROBIN_EN; M0 then M1 with it.
6. Assert rst in the cycle after an M0 read → no m0_rvalid; all outputs 0 the following cycle, state IDLE.
